// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp encodings and the control word shared by the pipeline control unit.
package ctrl_pkg;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_SLT = 6'h2A;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_JMP  = 2'b11;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control word, plus which source fields the instruction reads.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_word_t       word,
    output logic             uses_rs,
    output logic             uses_rt
);

    always_comb begin
        word    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND), OPC_W'(OP_OR), OPC_W'(OP_SLT): begin
                word.regdst   = 1'b1;
                word.regwrite = 1'b1;
                word.aluop    = ALU_FUNC;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OPC_W'(OP_LW): begin
                word.alusrc   = 1'b1;
                word.memread  = 1'b1;
                word.memtoreg = 1'b1;
                word.regwrite = 1'b1;
                word.aluop    = ALU_ADD;
                uses_rs       = 1'b1;
            end
            OPC_W'(OP_SW): begin
                word.alusrc   = 1'b1;
                word.memwrite = 1'b1;
                word.aluop    = ALU_ADD;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OPC_W'(OP_BEQ): begin
                word.branch = 1'b1;
                word.aluop  = ALU_SUB;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
            end
            OPC_W'(OP_J): begin
                word.jump  = 1'b1;
                word.aluop = ALU_JMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control with load-use stall and branch/jump flush.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush counters.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int RA_W  = 5
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             id_jump,
    output logic             ex_alusrc,
    output logic             ex_regdst,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic [1:0]       ex_aluop,
    output logic [RA_W-1:0]  ex_dst,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_memtoreg,
    output logic             mem_regwrite,
    output logic [RA_W-1:0]  mem_dst,
    output logic             wb_memtoreg,
    output logic             wb_regwrite,
    output logic [RA_W-1:0]  wb_dst
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    ctrl_word_t      id_w;
    logic            uses_rs;
    logic            uses_rt;
    logic            stall;
    logic            brflush;
    logic            squash;
    logic            id_wr;
    logic [RA_W-1:0] id_dst;
    logic            ex_memwrite;
    logic            ex_memtoreg;
    logic            ex_regwrite;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode  (id_opcode),
        .word    (id_w),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    // A taken branch squashes the ID instruction, so any stall it would raise is moot.
    always_comb begin
        brflush    = ex_branch && ex_br_taken;
        stall      = ex_memread && ex_dst != '0 &&
                     ((ex_dst == id_rs && uses_rs) || (ex_dst == id_rt && uses_rt));
        id_jump    = id_w.jump && !brflush && !stall;
        ifid_flush = brflush || id_jump;
        pc_write   = brflush || !stall;
        ifid_write = pc_write;
        squash     = brflush || stall || id_w.jump;
        id_dst     = id_w.regdst ? id_rd : id_rt;
        id_wr      = id_w.regwrite && id_dst != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite} <= '0;
            ex_aluop <= '0;
            ex_dst   <= '0;
            {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite} <= '0;
            mem_dst  <= '0;
            {wb_memtoreg, wb_regwrite} <= '0;
            wb_dst   <= '0;
        end else begin
            ex_alusrc    <= !squash && id_w.alusrc;
            ex_regdst    <= !squash && id_w.regdst;
            ex_branch    <= !squash && id_w.branch;
            ex_memread   <= !squash && id_w.memread;
            ex_memwrite  <= !squash && id_w.memwrite;
            ex_memtoreg  <= !squash && id_w.memtoreg;
            ex_regwrite  <= !squash && id_wr;
            ex_aluop     <= squash ? ALU_ADD : id_w.aluop;
            ex_dst       <= squash ? '0 : id_dst;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_regwrite <= ex_regwrite;
            mem_dst      <= ex_dst;
            wb_memtoreg  <= mem_memtoreg;
            wb_regwrite  <= mem_regwrite;
            wb_dst       <= mem_dst;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !brflush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed vector table, reset-in-stall sequence and a randomized run against a reference model.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_br_taken;
    logic       pc_write, ifid_write, ifid_flush, id_jump;
    logic       ex_alusrc, ex_regdst, ex_branch, ex_memread;
    logic [1:0] ex_aluop;
    logic [4:0] ex_dst;
    logic       mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic [4:0] mem_dst;
    logic       wb_memtoreg, wb_regwrite;
    logic [4:0] wb_dst;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_br_taken(ex_br_taken), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .id_jump(id_jump), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_branch(ex_branch),
        .ex_memread(ex_memread), .ex_aluop(ex_aluop), .ex_dst(ex_dst), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
        .mem_dst(mem_dst), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  ctl_a;
    logic [10:0] ex_a;
    logic [8:0]  mem_a;
    logic [6:0]  wb_a;
    assign ctl_a = {pc_write, ifid_write, ifid_flush, id_jump};
    assign ex_a  = {ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_aluop, ex_dst};
    assign mem_a = {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_dst};
    assign wb_a  = {wb_memtoreg, wb_regwrite, wb_dst};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] exv(logic a, logic r, logic b, logic m, logic [1:0] op, logic [4:0] d);
        return {a, r, b, m, op, d};
    endfunction

    function automatic logic [8:0] mv(logic mr, logic mw, logic mt, logic rw, logic [4:0] d);
        return {mr, mw, mt, rw, d};
    endfunction

    function automatic logic [6:0] wv(logic mt, logic rw, logic [4:0] d);
        return {mt, rw, d};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        br;
        logic [3:0]  ctl;
        logic [10:0] ex;
        logic [8:0]  mem;
        logic [6:0]  wb;
    } vec_t;

    // Instruction as seen by the model: what it does and where it writes.
    typedef struct packed {
        logic       regdst, alusrc, branch, jump, memread, memwrite, memtoreg, regwrite;
        logic [1:0] aluop;
        logic [4:0] dst;
        logic       use_rs, use_rt;
    } ref_t;

    function automatic ref_t dec(logic [5:0] op, logic [4:0] rt, logic [4:0] rd);
        ref_t r = '0;
        if (op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
            r.regdst = 1; r.regwrite = 1; r.aluop = 2'b10; r.use_rs = 1; r.use_rt = 1;
        end else if (op == 6'h23) begin
            r.alusrc = 1; r.memread = 1; r.memtoreg = 1; r.regwrite = 1; r.use_rs = 1;
        end else if (op == 6'h2B) begin
            r.alusrc = 1; r.memwrite = 1; r.use_rs = 1; r.use_rt = 1;
        end else if (op == 6'h04) begin
            r.branch = 1; r.aluop = 2'b01; r.use_rs = 1; r.use_rt = 1;
        end else if (op == 6'h02) begin
            r.jump = 1; r.aluop = 2'b11;
        end
        r.dst = r.regdst ? rd : rt;
        if (r.dst == 0) r.regwrite = 0;
        return r;
    endfunction

    ref_t hist[$];
    int   m_stalls, m_flushes;
    logic last_stall;

    task automatic model_reset();
        hist = {};
        repeat (3) hist.push_back('0);
        m_stalls = 0;
        m_flushes = 0;
        last_stall = 0;
    endtask

    // hist[2] is in EX, hist[1] in MEM, hist[0] in WB.
    task automatic rnd_step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic br);
        ref_t d, ex, mem, wb, nxt;
        logic brf, stl;
        logic [3:0] ctl_e;
        id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
        #2;
        d = dec(op, rt, rd);
        ex = hist[2]; mem = hist[1]; wb = hist[0];
        brf = ex.branch && br;
        stl = ex.memread && ex.dst != 0 && ((ex.dst == rs && d.use_rs) || (ex.dst == rt && d.use_rt));
        nxt = '0;
        if (brf) begin
            ctl_e = 4'b1110; m_flushes++;
        end else if (stl) begin
            ctl_e = 4'b0000; m_stalls++;
        end else if (d.jump) begin
            ctl_e = 4'b1111; m_flushes++;
        end else begin
            ctl_e = 4'b1100; nxt = d;
        end
        last_stall = stl && !brf;
        chk("rnd_ctl", 16'(ctl_a), 16'(ctl_e));
        chk("rnd_ex", 16'(ex_a), 16'(exv(ex.alusrc, ex.regdst, ex.branch, ex.memread, ex.aluop, ex.dst)));
        chk("rnd_mem", 16'(mem_a), 16'(mv(mem.memread, mem.memwrite, mem.memtoreg, mem.regwrite, mem.dst)));
        chk("rnd_wb", 16'(wb_a), 16'(wv(wb.memtoreg, wb.regwrite, wb.dst)));
        @(posedge clk);
        hist.push_back(nxt);
        void'(hist.pop_front());
        #1;
    endtask

    function automatic vec_t mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic br,
                                logic [3:0] ctl, logic [10:0] ex, logic [8:0] mem, logic [6:0] wb);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.br = br;
        v.ctl = ctl; v.ex = ex; v.mem = mem; v.wb = wb;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [5:0] ops[10];
        logic [5:0] op;
        logic [4:0] rs, rt, rd;

        tbl.push_back(mk(6'h00, 0, 0, 0, 0, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(6'h20, 1, 2, 3, 0, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(6'h00, 0, 0, 0, 0, 4'b1100, exv(0, 1, 0, 0, 2'b10, 3), 0, 0));
        tbl.push_back(mk(6'h00, 0, 0, 0, 0, 4'b1100, 0, mv(0, 0, 0, 1, 3), 0));
        tbl.push_back(mk(6'h00, 0, 0, 0, 0, 4'b1100, 0, 0, wv(0, 1, 3)));
        tbl.push_back(mk(6'h23, 1, 5, 0, 0, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(6'h20, 5, 2, 4, 0, 4'b0000, exv(1, 0, 0, 1, 2'b00, 5), 0, 0));
        tbl.push_back(mk(6'h20, 5, 2, 4, 0, 4'b1100, 0, mv(1, 0, 1, 1, 5), 0));
        tbl.push_back(mk(6'h23, 0, 5, 0, 0, 4'b1100, exv(0, 1, 0, 0, 2'b10, 4), 0, wv(1, 1, 5)));
        tbl.push_back(mk(6'h23, 0, 6, 0, 0, 4'b1100, exv(1, 0, 0, 1, 2'b00, 5), mv(0, 0, 0, 1, 4), 0));
        tbl.push_back(mk(6'h23, 0, 0, 0, 0, 4'b1100, exv(1, 0, 0, 1, 2'b00, 6), mv(1, 0, 1, 1, 5), wv(0, 1, 4)));
        tbl.push_back(mk(6'h20, 0, 0, 7, 0, 4'b1100, exv(1, 0, 0, 1, 2'b00, 0), mv(1, 0, 1, 1, 6), wv(1, 1, 5)));
        tbl.push_back(mk(6'h04, 1, 2, 0, 0, 4'b1100, exv(0, 1, 0, 0, 2'b10, 7), mv(1, 0, 1, 0, 0), wv(1, 1, 6)));
        tbl.push_back(mk(6'h20, 2, 2, 9, 1, 4'b1110, exv(0, 0, 1, 0, 2'b01, 2), mv(0, 0, 0, 1, 7), wv(1, 0, 0)));
        tbl.push_back(mk(6'h02, 0, 0, 0, 1, 4'b1111, 0, mv(0, 0, 0, 0, 2), wv(0, 1, 7)));
        tbl.push_back(mk(6'h3F, 1, 0, 3, 0, 4'b1100, 0, 0, wv(0, 0, 2)));
        tbl.push_back(mk(6'h04, 0, 3, 0, 0, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(6'h02, 0, 0, 0, 1, 4'b1110, exv(0, 0, 1, 0, 2'b01, 3), 0, 0));
        tbl.push_back(mk(6'h00, 0, 0, 0, 0, 4'b1100, 0, mv(0, 0, 0, 0, 3), 0));

        rst = 1; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0; ex_br_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 16'(ctl_a), 16'(4'b1100));
        chk("reset_ex", 16'(ex_a), 16'h0);
        chk("reset_mem", 16'(mem_a), 16'h0);
        chk("reset_wb", 16'(wb_a), 16'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("reset_cnt", stall_cnt | flush_cnt, 16'h0);
`endif
        rst = 0;

        foreach (tbl[i]) begin
            id_opcode = tbl[i].op; id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_rd = tbl[i].rd;
            ex_br_taken = tbl[i].br;
            #2;
            chk($sformatf("v%0d_ctl", i), 16'(ctl_a), 16'(tbl[i].ctl));
            chk($sformatf("v%0d_ex", i), 16'(ex_a), 16'(tbl[i].ex));
            chk($sformatf("v%0d_mem", i), 16'(mem_a), 16'(tbl[i].mem));
            chk($sformatf("v%0d_wb", i), 16'(wb_a), 16'(tbl[i].wb));
            @(posedge clk);
            #1;
        end

        // Reset lands while a load-use stall is active: the lw must not reach MEM.
        id_opcode = 6'h23; id_rs = 0; id_rt = 5; id_rd = 0; ex_br_taken = 0;
        @(posedge clk);
        #1;
        id_opcode = 6'h20; id_rs = 5; id_rt = 0; id_rd = 4;
        #2;
        chk("rst_stall_pre", 16'(ctl_a), 16'(4'b0000));
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("rst_stall_ex", 16'(ex_a), 16'h0);
        chk("rst_stall_mem", 16'(mem_a), 16'h0);
        chk("rst_stall_ctl", 16'(ctl_a), 16'(4'b1100));
        model_reset();

        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        op = 0; rs = 0; rt = 0; rd = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1;
                @(posedge clk);
                #1;
                rst = 0;
                model_reset();
            end
            if (!last_stall) begin
                op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
                if ($urandom_range(0, 2) == 0) op = 6'h23;
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
            end
            rnd_step(op, rs, rt, rd, 1'($urandom));
        end
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, 16'(m_stalls));
        chk("flush_cnt", flush_cnt, 16'(m_flushes));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
